// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-source memory arbiter: FSM states, owner
// encoding and the default response timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arbOwner_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/mem_arbiter_req_slot.sv
// One pending-request slot: captures a request pulse, flags dropped pulses
// as a sticky overrun, and empties when the arbiter grants it.
module arb_req_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid_i,
  input  logic        wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  input  logic        ownsInFlight_i,
  input  logic        grant_i,
  output logic        pending_o,
  output logic        wen_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  output logic        overrun_o
);

  logic        pending_q, pending_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        overrun_q, overrun_d;
  logic        accept;

  // A pulse is only taken into an empty slot whose source has nothing in flight.
  assign accept = reqValid_i && !pending_q && !ownsInFlight_i;

  always_comb begin
    pending_d = pending_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    overrun_d = overrun_q;
    if (grant_i) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      pending_d = 1'b1;
      wen_d     = wen_i;
      addr_d    = addr_i;
      wdata_d   = wdata_i;
      wmask_d   = wmask_i;
    end else if (reqValid_i) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign wen_o     = wen_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign wmask_o   = wmask_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU requests onto one single-outstanding memory port,
// LSU first, with a response timeout so a lost response never hangs a source.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_respErr,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_respErr,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_CNT = CNT_W'(TO_LAST);

  arbState_e   state_q, state_d;
  arbOwner_e   owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        memWen_q, memWen_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [3:0]  memWmask_q, memWmask_d;
  logic        ifuRespValid_q, ifuRespValid_d;
  logic [31:0] ifuRdata_q, ifuRdata_d;
  logic        ifuRespErr_q, ifuRespErr_d;
  logic        lsuRespValid_q, lsuRespValid_d;
  logic [31:0] lsuRdata_q, lsuRdata_d;
  logic        lsuRespErr_q, lsuRespErr_d;

  logic        ifuPending, lsuPending;
  logic        ifuGrant, lsuGrant;
  logic        ifuOwns, lsuOwns;
  logic        ifuSlotWen, lsuSlotWen;
  logic [31:0] ifuSlotAddr, lsuSlotAddr;
  logic [31:0] ifuSlotWdata, lsuSlotWdata;
  logic [3:0]  ifuSlotWmask, lsuSlotWmask;
  logic        ifuOverrun, lsuOverrun;
  logic        deliver, deliverErr;
  logic [31:0] deliverData;

  assign ifuOwns = (state_q != ARB_IDLE) && (owner_q == OWN_IFU);
  assign lsuOwns = (state_q != ARB_IDLE) && (owner_q == OWN_LSU);

  arb_req_slot u_ifuSlot (
    .clock          (clock),
    .reset          (reset),
    .reqValid_i     (ifu_reqValid),
    .wen_i          (1'b0),
    .addr_i         (ifu_addr),
    .wdata_i        (32'h0),
    .wmask_i        (4'h0),
    .ownsInFlight_i (ifuOwns),
    .grant_i        (ifuGrant),
    .pending_o      (ifuPending),
    .wen_o          (ifuSlotWen),
    .addr_o         (ifuSlotAddr),
    .wdata_o        (ifuSlotWdata),
    .wmask_o        (ifuSlotWmask),
    .overrun_o      (ifuOverrun)
  );

  arb_req_slot u_lsuSlot (
    .clock          (clock),
    .reset          (reset),
    .reqValid_i     (lsu_reqValid),
    .wen_i          (lsu_wen),
    .addr_i         (lsu_addr),
    .wdata_i        (lsu_wdata),
    .wmask_i        (lsu_wmask),
    .ownsInFlight_i (lsuOwns),
    .grant_i        (lsuGrant),
    .pending_o      (lsuPending),
    .wen_o          (lsuSlotWen),
    .addr_o         (lsuSlotAddr),
    .wdata_o        (lsuSlotWdata),
    .wmask_o        (lsuSlotWmask),
    .overrun_o      (lsuOverrun)
  );

  // Next-state logic; a real response in the same cycle as the timeout wins.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    memWen_d       = memWen_q;
    memAddr_d      = memAddr_q;
    memWdata_d     = memWdata_q;
    memWmask_d     = memWmask_q;
    ifuGrant       = 1'b0;
    lsuGrant       = 1'b0;
    deliver        = 1'b0;
    deliverErr     = 1'b0;
    deliverData    = 32'h0;
    case (state_q)
      ARB_IDLE: begin
        if (lsuPending) begin
          lsuGrant   = 1'b1;
          owner_d    = OWN_LSU;
          memWen_d   = lsuSlotWen;
          memAddr_d  = lsuSlotAddr;
          memWdata_d = lsuSlotWdata;
          memWmask_d = lsuSlotWmask;
          state_d    = ARB_ISSUE;
        end else if (ifuPending) begin
          ifuGrant   = 1'b1;
          owner_d    = OWN_IFU;
          memWen_d   = ifuSlotWen;
          memAddr_d  = ifuSlotAddr;
          memWdata_d = ifuSlotWdata;
          memWmask_d = ifuSlotWmask;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_reqReady) begin
          cnt_d   = '0;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_respValid) begin
          deliver     = 1'b1;
          deliverData = memWen_q ? 32'h0 : mem_rdata;
          state_d     = ARB_IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST_CNT)) begin
          deliver    = 1'b1;
          deliverErr = 1'b1;
          state_d    = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Response routing to whichever source owns the finishing transaction.
  always_comb begin
    ifuRespValid_d = 1'b0;
    ifuRdata_d     = ifuRdata_q;
    ifuRespErr_d   = ifuRespErr_q;
    lsuRespValid_d = 1'b0;
    lsuRdata_d     = lsuRdata_q;
    lsuRespErr_d   = lsuRespErr_q;
    if (deliver) begin
      if (owner_q == OWN_LSU) begin
        lsuRespValid_d = 1'b1;
        lsuRdata_d     = deliverData;
        lsuRespErr_d   = deliverErr;
      end else begin
        ifuRespValid_d = 1'b1;
        ifuRdata_d     = deliverData;
        ifuRespErr_d   = deliverErr;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_IFU;
      cnt_q          <= '0;
      memWen_q       <= 1'b0;
      memAddr_q      <= '0;
      memWdata_q     <= '0;
      memWmask_q     <= '0;
      ifuRespValid_q <= 1'b0;
      ifuRdata_q     <= '0;
      ifuRespErr_q   <= 1'b0;
      lsuRespValid_q <= 1'b0;
      lsuRdata_q     <= '0;
      lsuRespErr_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      memWen_q       <= memWen_d;
      memAddr_q      <= memAddr_d;
      memWdata_q     <= memWdata_d;
      memWmask_q     <= memWmask_d;
      ifuRespValid_q <= ifuRespValid_d;
      ifuRdata_q     <= ifuRdata_d;
      ifuRespErr_q   <= ifuRespErr_d;
      lsuRespValid_q <= lsuRespValid_d;
      lsuRdata_q     <= lsuRdata_d;
      lsuRespErr_q   <= lsuRespErr_d;
    end
  end

  assign mem_reqValid  = (state_q == ARB_ISSUE);
  assign mem_wen       = memWen_q;
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign mem_wmask     = memWmask_q;
  assign ifu_respValid = ifuRespValid_q;
  assign ifu_rdata     = ifuRdata_q;
  assign ifu_respErr   = ifuRespErr_q;
  assign lsu_respValid = lsuRespValid_q;
  assign lsu_rdata     = lsuRdata_q;
  assign lsu_respErr   = lsuRespErr_q;
  assign busy          = (state_q != ARB_IDLE) || ifuPending || lsuPending;
  assign overrun       = ifuOverrun || lsuOverrun;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, built with an 8-cycle
// timeout so the lost-response path is reachable quickly.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_respErr;
  logic        lsu_reqValid;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_respErr;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        overrun;

  int checks;
  int failures;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .ifu_respErr   (ifu_respErr),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .lsu_respErr   (lsu_respErr),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_reqReady = 0; mem_respValid = 0; mem_rdata = 0;
    step(); step();
    checks++; if ({mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== 70'h0) begin failures++; $display("[TB] FAIL reset_mem got=%h exp=0", {mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask}); end
    checks++; if ({ifu_respValid, ifu_rdata, ifu_respErr, lsu_respValid, lsu_rdata, lsu_respErr} !== 68'h0) begin failures++; $display("[TB] FAIL reset_resp got=%h exp=0", {ifu_respValid, ifu_rdata, ifu_respErr, lsu_respValid, lsu_rdata, lsu_respErr}); end
    checks++; if ({busy, overrun} !== 2'b00) begin failures++; $display("[TB] FAIL reset_status got=%b exp=00", {busy, overrun}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    ifu_reqValid = 1; ifu_addr = 32'h8000_0000; mem_reqReady = 1;
    step();
    ifu_reqValid = 0;
    checks++; if ({mem_reqValid, busy} !== 2'b01) begin failures++; $display("[TB] FAIL fetch_pending got=%b exp=01", {mem_reqValid, busy}); end
    step();
    checks++; if ({mem_reqValid, mem_wen} !== 2'b10) begin failures++; $display("[TB] FAIL fetch_issue got=%b exp=10", {mem_reqValid, mem_wen}); end
    checks++; if (mem_addr !== 32'h8000_0000) begin failures++; $display("[TB] FAIL fetch_addr got=%h exp=80000000", mem_addr); end
    step();
    checks++; if (mem_reqValid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_accepted got=%b exp=0", mem_reqValid); end
    mem_respValid = 1; mem_rdata = 32'h0000_0013;
    step();
    mem_respValid = 0;
    checks++; if ({ifu_respValid, ifu_respErr, lsu_respValid} !== 3'b100) begin failures++; $display("[TB] FAIL fetch_resp got=%b exp=100", {ifu_respValid, ifu_respErr, lsu_respValid}); end
    checks++; if (ifu_rdata !== 32'h0000_0013) begin failures++; $display("[TB] FAIL fetch_rdata got=%h exp=00000013", ifu_rdata); end
    step();
    checks++; if ({ifu_respValid, busy} !== 2'b00) begin failures++; $display("[TB] FAIL fetch_done got=%b exp=00", {ifu_respValid, busy}); end
    checks++; if (ifu_rdata !== 32'h0000_0013) begin failures++; $display("[TB] FAIL fetch_rdata_hold got=%h exp=00000013", ifu_rdata); end
  endtask

  task automatic test_simultaneous();
    ifu_reqValid = 1; ifu_addr = 32'h8000_0004;
    lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h1000_0000; lsu_wdata = 32'h41; lsu_wmask = 4'h1;
    step();
    ifu_reqValid = 0; lsu_reqValid = 0;
    step();
    checks++; if ({mem_reqValid, mem_wen, mem_wmask} !== 6'b11_0001) begin failures++; $display("[TB] FAIL simul_store_issue got=%b exp=110001", {mem_reqValid, mem_wen, mem_wmask}); end
    checks++; if ({mem_addr, mem_wdata} !== {32'h1000_0000, 32'h0000_0041}) begin failures++; $display("[TB] FAIL simul_store_addr got=%h exp=1000000000000041", {mem_addr, mem_wdata}); end
    step();
    mem_respValid = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_respValid = 0;
    checks++; if ({lsu_respValid, lsu_respErr, ifu_respValid} !== 3'b100) begin failures++; $display("[TB] FAIL simul_store_resp got=%b exp=100", {lsu_respValid, lsu_respErr, ifu_respValid}); end
    checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("[TB] FAIL simul_store_rdata got=%h exp=00000000", lsu_rdata); end
    step();
    checks++; if ({mem_reqValid, mem_wen, mem_wmask} !== 6'b10_0000) begin failures++; $display("[TB] FAIL simul_fetch_issue got=%b exp=100000", {mem_reqValid, mem_wen, mem_wmask}); end
    checks++; if (mem_addr !== 32'h8000_0004) begin failures++; $display("[TB] FAIL simul_fetch_addr got=%h exp=80000004", mem_addr); end
    step();
    mem_respValid = 1; mem_rdata = 32'h0000_0093;
    step();
    mem_respValid = 0;
    checks++; if ({ifu_respValid, lsu_respValid, overrun} !== 3'b100) begin failures++; $display("[TB] FAIL simul_fetch_resp got=%b exp=100", {ifu_respValid, lsu_respValid, overrun}); end
    checks++; if (ifu_rdata !== 32'h0000_0093) begin failures++; $display("[TB] FAIL simul_fetch_rdata got=%h exp=00000093", ifu_rdata); end
    step();
  endtask

  task automatic test_backpressure();
    lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h3000_0000; lsu_wdata = 0; lsu_wmask = 0;
    mem_reqReady = 0;
    step();
    lsu_reqValid = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++; if ({mem_reqValid, mem_addr} !== {1'b1, 32'h3000_0000}) begin failures++; $display("[TB] FAIL bp_hold_%0d got=%h exp=130000000", i, {mem_reqValid, mem_addr}); end
      if (i == 5) mem_reqReady = 1;
      step();
    end
    checks++; if (mem_reqValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_accepted got=%b exp=0", mem_reqValid); end
    mem_respValid = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_respValid = 0;
    checks++; if ({lsu_respValid, lsu_respErr, lsu_rdata} !== {2'b10, 32'hCAFE_F00D}) begin failures++; $display("[TB] FAIL bp_resp got=%h exp=2cafef00d", {lsu_respValid, lsu_respErr, lsu_rdata}); end
    step();
  endtask

  task automatic test_timeout();
    lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h2000_0000;
    step();
    lsu_reqValid = 0;
    step();
    checks++; if ({mem_reqValid, mem_addr} !== {1'b1, 32'h2000_0000}) begin failures++; $display("[TB] FAIL to_issue got=%h exp=120000000", {mem_reqValid, mem_addr}); end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (lsu_respValid !== 1'b0) begin failures++; $display("[TB] FAIL to_early_%0d got=%b exp=0", i, lsu_respValid); end
      step();
    end
    checks++; if ({lsu_respValid, lsu_respErr, lsu_rdata} !== {2'b11, 32'h0}) begin failures++; $display("[TB] FAIL to_resp got=%h exp=300000000", {lsu_respValid, lsu_respErr, lsu_rdata}); end
    mem_respValid = 1; mem_rdata = 32'h0000_0BAD;
    step();
    mem_respValid = 0;
    checks++; if ({lsu_respValid, ifu_respValid, busy, lsu_respErr} !== 4'b0001) begin failures++; $display("[TB] FAIL to_late_ignored got=%b exp=0001", {lsu_respValid, ifu_respValid, busy, lsu_respErr}); end
    step();
  endtask

  task automatic test_overrun();
    ifu_reqValid = 1; ifu_addr = 32'h8000_0010;
    step();
    ifu_reqValid = 0;
    step();
    step();
    ifu_reqValid = 1; ifu_addr = 32'hFFFF_FFF0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_before got=%b exp=0", overrun); end
    step();
    ifu_reqValid = 0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set got=%b exp=1", overrun); end
    mem_respValid = 1; mem_rdata = 32'h0000_0777;
    step();
    mem_respValid = 0;
    checks++; if ({ifu_respValid, ifu_respErr, ifu_rdata} !== {2'b10, 32'h0000_0777}) begin failures++; $display("[TB] FAIL ovr_resp got=%h exp=200000777", {ifu_respValid, ifu_respErr, ifu_rdata}); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({ifu_respValid, mem_reqValid, busy, overrun} !== 4'b0001) begin failures++; $display("[TB] FAIL ovr_quiet_%0d got=%b exp=0001", i, {ifu_respValid, mem_reqValid, busy, overrun}); end
    end
  endtask

  task automatic test_reset_mid_wait();
    lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h4000_0000;
    step();
    lsu_reqValid = 0;
    step();
    step();
    #1 reset = 1'b1;
    #1;
    checks++; if ({busy, overrun, mem_reqValid, mem_addr} !== 35'h0) begin failures++; $display("[TB] FAIL rst_async got=%h exp=0", {busy, overrun, mem_reqValid, mem_addr}); end
    checks++; if ({ifu_rdata, lsu_respErr} !== 33'h0) begin failures++; $display("[TB] FAIL rst_resp_regs got=%h exp=0", {ifu_rdata, lsu_respErr}); end
    step();
    reset = 1'b0;
    step();
    mem_respValid = 1; mem_rdata = 32'h0000_0099;
    step();
    mem_respValid = 0;
    checks++; if ({lsu_respValid, ifu_respValid, busy, mem_reqValid} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_late_resp got=%b exp=0000", {lsu_respValid, ifu_respValid, busy, mem_reqValid}); end
    checks++; if (lsu_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_lsu_rdata got=%h exp=00000000", lsu_rdata); end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-outstanding memory port between the instruction fetch requester (IFU) and the load/store requester (LSU).
- Requesters issue one-cycle request pulses. The arbiter latches them into per-source pending slots, issues them one at a time on the memory port with a valid/ready request handshake, and routes the response back as a one-cycle pulse.
- A response timeout guarantees that the requester's sequencing FSM never hangs on a lost response.
- Sits between the core sequencer and the SoC memory/bus fabric.

Parameters:
- TIMEOUT_CYCLES, 256: WAIT-state cycles before a synthetic error response. 0 disables the timeout.
- CNT_W, 16: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ifu_reqValid  in  1  one-cycle fetch request pulse
- ifu_addr  in  32  fetch address, sampled with ifu_reqValid
- ifu_respValid  out  1  one-cycle fetch response pulse
- ifu_rdata  out  32  fetch data, valid with ifu_respValid
- ifu_respErr  out  1  timeout error, valid with ifu_respValid
- lsu_reqValid  in  1  one-cycle load/store request pulse
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  32  load/store address
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte strobes
- lsu_respValid  out  1  one-cycle load/store response pulse
- lsu_rdata  out  32  load data (0 for stores)
- lsu_respErr  out  1  timeout error
- mem_reqValid  out  1  memory request valid
- mem_reqReady  in  1  memory accepts the request
- mem_wen  out  1  write enable
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_wmask  out  4  write strobes
- mem_respValid  in  1  memory response
- mem_rdata  in  32  memory read data
- busy  out  1  1 whenever the FSM is not IDLE or any pending slot is set
- overrun  out  1  sticky; set when a request is dropped

Behaviour:
- Reset values: all outputs 0, both pending slots empty, state IDLE, counter 0. Reset is asynchronous and can occur mid-transaction. It abandons the transaction and the owner. A mem_respValid arriving afterwards while the FSM is IDLE is ignored.
- Capture:
  - A reqValid pulse loads that source's pending slot (address, plus wen/wdata/wmask for the LSU) at the clock edge.
  - If the same source's slot is already pending, or that source owns the in-flight transaction, the new pulse is dropped, the slot is left unchanged, and overrun is set to 1 until reset.
- Arbitration: fixed priority, LSU over IFU. Evaluated only in IDLE.
- FSM states:
  - IDLE: if any slot is pending, select the owner (LSU first), clear its pending flag, load the mem_* output registers from its slot, go to ISSUE. Otherwise stay.
  - ISSUE: mem_reqValid=1 with mem_* held stable until mem_reqReady=1, then go to WAIT and clear the counter. A mem_respValid seen in ISSUE is ignored.
  - WAIT: on mem_respValid, register mem_rdata into the owner's rdata (0 for a store), pulse the owner's respValid for one cycle with respErr=0, go to IDLE. Otherwise increment the counter.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without a response, pulse the owner's respValid with respErr=1 and rdata=0, go to IDLE.
    - A mem_respValid arriving in the same cycle as the timeout takes precedence (normal response).
    - A late mem_respValid arriving while IDLE is ignored.
- rdata and respErr hold their values until the next response to the same source.
- Latency:
  - Request pulse at cycle N, with mem_reqReady=1 and the memory answering one cycle after acceptance: mem_reqValid at N+2, mem_respValid at N+3, requester respValid at N+4.
  - The next pending request issues at the earliest in the cycle after a response pulse (IDLE→ISSUE, one bubble).
- Simultaneous pulses from both sources in one cycle: both are captured. LSU is served first, IFU immediately after.
- A request pulse arriving in the same cycle a transaction is issued from a different source's slot is captured normally.
- At most one memory transaction is outstanding. mem_* outputs change only in IDLE→ISSUE.

Decomposition:
- Shared defs package holds: the arbiter state encoding (ARB_IDLE, ARB_ISSUE, ARB_WAIT), owner encoding (OWN_IFU=0, OWN_LSU=1), and the default TIMEOUT_CYCLES constant.
- One sub-module, arb_req_slot: a pending-slot register with capture, overrun detection and clear-on-grant. It is instantiated twice (IFU without write fields tied off, LSU with them).

Test Plan:
- Single fetch: ifu_reqValid at cycle 0 with ifu_addr=0x8000_0000, ready=1, mem answers 0x0000_0013 one cycle after acceptance → mem_addr=0x8000_0000, mem_wen=0; ifu_respValid pulses at cycle 4 with ifu_rdata=0x0000_0013, ifu_respErr=0.
- Simultaneous: both request in one cycle (IFU 0x8000_0004; LSU store 0x1000_0000, wdata=0x41, wmask=0x1) → the store issues first with mem_wen=1 and mem_wmask=0x1, then the fetch; lsu_respValid precedes ifu_respValid; overrun stays 0.
- Backpressure: mem_reqReady held 0 for 5 cycles → mem_reqValid and mem_addr stay stable for 6 cycles; the response routes correctly after that.
- Timeout: TIMEOUT_CYCLES=8, memory never responds to a load at 0x2000_0000 → lsu_respValid pulses with lsu_respErr=1 and lsu_rdata=0 after 8 WAIT cycles. A late mem_respValid is then ignored, with no extra pulse.
- Overrun: a second ifu_reqValid while the first fetch is in WAIT → overrun=1 permanently, only one ifu_respValid occurs, and the slot data is unchanged.
- Reset mid-WAIT: assert reset during WAIT, then mem_respValid after release → no respValid pulse; all outputs 0; busy=0.
